core_frame_receiver: RTL and testbench

- Core-side end of the scheduler frame link; one instance per core.
- Accepts a framed program/data stream from the scheduler: a header word followed by N payload words.
- Buffers the payload in a local word store and exposes it to the core through a read port.
- Drives core_read_f to tell the scheduler whether the core can take a new frame.

---
 rtl/core_frame_receiver.sv | 176 +++++++++++++++++
 tb/tb_core_frame_receiver.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_frame_receiver.sv
// Core-side frame receiver: takes a header plus N payload words from the
// scheduler link, stores the payload and exposes it through a registered read port.
module core_frame_receiver #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_being_sent,
    input  logic [DATA_W-1:0] frame_word,
    output logic              core_read_f,
    output logic              frame_ready,
    output logic [ADDR_W:0]   frame_len,
    input  logic              frame_release,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              frame_done,
    output logic              len_err,
    output logic              proto_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DROP  = 2'd2,
        S_READY = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_wptr;
    logic [ADDR_W:0]     r_frame_len;
    logic [DATA_W-1:0]   r_drop_cnt;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_frame_done;
    logic                r_len_err;
    logic                r_proto_err;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    state_t              w_state_nxt;
    logic [ADDR_W:0]     w_hdr_len;
    logic                w_hdr_over;
    logic                w_last;
    logic                w_wr_en;
    logic                w_done;
    logic                w_len_load;
    logic                w_wptr_clr;
    logic                w_wptr_inc;
    logic                w_drop_load;
    logic                w_drop_dec;
    logic                w_len_err_set;
    logic                w_proto_set;

    assign w_hdr_len  = frame_word[ADDR_W:0];
    // Any nonzero bit above the length field means the frame cannot fit.
    assign w_hdr_over = (|frame_word[DATA_W-1:ADDR_W+1]) || (w_hdr_len > DEPTH_L);
    assign w_last     = ({1'b0, r_wptr} == (r_frame_len - (ADDR_W+1)'(1)));

    // Next-state and datapath control decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_wr_en       = 1'b0;
        w_done        = 1'b0;
        w_len_load    = 1'b0;
        w_wptr_clr    = 1'b0;
        w_wptr_inc    = 1'b0;
        w_drop_load   = 1'b0;
        w_drop_dec    = 1'b0;
        w_len_err_set = 1'b0;
        w_proto_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (frame_being_sent) begin
                    if (w_hdr_over) begin
                        w_len_err_set = 1'b1;
                        w_drop_load   = 1'b1;
                        w_state_nxt   = S_DROP;
                    end else if (w_hdr_len == '0) begin
                        w_len_load  = 1'b1;
                        w_done      = 1'b1;
                        w_state_nxt = S_READY;
                    end else begin
                        w_len_load  = 1'b1;
                        w_wptr_clr  = 1'b1;
                        w_state_nxt = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (frame_being_sent) begin
                    w_wr_en = 1'b1;
                    if (w_last) begin
                        w_done      = 1'b1;
                        w_state_nxt = S_READY;
                    end else begin
                        w_wptr_inc = 1'b1;
                    end
                end
            end
            S_DROP: begin
                if (frame_being_sent) begin
                    w_drop_dec = 1'b1;
                    if (r_drop_cnt == DATA_W'(1)) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_READY: begin
                if (frame_being_sent) begin
                    w_proto_set = 1'b1;
                end
                if (frame_release) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register plus pointers, counters, flags and the registered read port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_wptr       <= '0;
            r_frame_len  <= '0;
            r_drop_cnt   <= '0;
            r_rd_data    <= '0;
            r_frame_done <= 1'b0;
            r_len_err    <= 1'b0;
            r_proto_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_done <= w_done;
            r_rd_data    <= r_mem[rd_addr];
            if (w_len_load) begin
                r_frame_len <= w_hdr_len;
            end
            if (w_wptr_clr) begin
                r_wptr <= '0;
            end else if (w_wptr_inc) begin
                r_wptr <= r_wptr + ADDR_W'(1);
            end
            // The discard counter takes the whole header word so oversize
            // lengths with upper bits set are still counted out in full.
            if (w_drop_load) begin
                r_drop_cnt <= frame_word;
            end else if (w_drop_dec) begin
                r_drop_cnt <= r_drop_cnt - DATA_W'(1);
            end
            if (w_len_err_set) begin
                r_len_err <= 1'b1;
            end
            if (w_proto_set) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    // Payload store write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr] <= frame_word;
        end
    end

    assign core_read_f = (r_state == S_IDLE);
    assign frame_ready = (r_state == S_READY);
    assign frame_len   = r_frame_len;
    assign rd_data     = r_rd_data;
    assign frame_done  = r_frame_done;
    assign len_err     = r_len_err;
    assign proto_err   = r_proto_err;

endmodule

// File: tb/tb_core_frame_receiver.sv
// Directed bench for core_frame_receiver with a read-data scoreboard.
module tb_core_frame_receiver;

    logic        clk;
    logic        reset;
    logic        frame_being_sent;
    logic [15:0] frame_word;
    logic        core_read_f;
    logic        frame_ready;
    logic [6:0]  frame_len;
    logic        frame_release;
    logic [5:0]  rd_addr;
    logic [15:0] rd_data;
    logic        frame_done;
    logic        len_err;
    logic        proto_err;

    int unsigned n_vec;
    int unsigned n_err;
    logic [15:0] exp_mem [64];
    logic [31:0] exp_q [$];

    core_frame_receiver #(.DATA_W(16), .DEPTH(64), .ADDR_W(6)) dut (
        .clk              (clk),
        .reset            (reset),
        .frame_being_sent (frame_being_sent),
        .frame_word       (frame_word),
        .core_read_f      (core_read_f),
        .frame_ready      (frame_ready),
        .frame_len        (frame_len),
        .frame_release    (frame_release),
        .rd_addr          (rd_addr),
        .rd_data          (rd_data),
        .frame_done       (frame_done),
        .len_err          (len_err),
        .proto_err        (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, vectors=%0d miscompares=%0d", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [15:0] w);
        frame_being_sent = 1'b1;
        frame_word       = w;
        step();
        frame_being_sent = 1'b0;
        frame_word       = '0;
    endtask

    task automatic payload(input int unsigned idx, input logic [15:0] w);
        exp_mem[idx] = w;
        drive(w);
    endtask

    task automatic rd_check(input int unsigned a);
        rd_addr = 6'(a);
        exp_q.push_back(32'(exp_mem[a]));
        step();
        chk($sformatf("rd_data[%0d]", a), 32'(rd_data), exp_q.pop_front());
    endtask

    task automatic release_frame();
        frame_release = 1'b1;
        step();
        frame_release = 1'b0;
    endtask

    initial begin
        n_vec            = 0;
        n_err            = 0;
        reset            = 1'b0;
        frame_being_sent = 1'b0;
        frame_word       = '0;
        frame_release    = 1'b0;
        rd_addr          = '0;

        // Reset state
        #12;
        chk("rst core_read_f", 32'(core_read_f), 1);
        chk("rst frame_ready", 32'(frame_ready), 0);
        chk("rst frame_len",   32'(frame_len),   0);
        chk("rst rd_data",     32'(rd_data),     0);
        chk("rst frame_done",  32'(frame_done),  0);
        chk("rst len_err",     32'(len_err),     0);
        chk("rst proto_err",   32'(proto_err),   0);
        reset = 1'b1;
        step();
        chk("idle core_read_f", 32'(core_read_f), 1);

        // Frame A: 3 words back to back
        drive(16'h0003);
        chk("A hdr core_read_f", 32'(core_read_f), 0);
        payload(0, 16'h000F);
        chk("A w0 done", 32'(frame_done), 0);
        payload(1, 16'h000F);
        chk("A w1 done", 32'(frame_done), 0);
        payload(2, 16'hABCD);
        chk("A done",      32'(frame_done),  1);
        chk("A ready",     32'(frame_ready), 1);
        chk("A frame_len", 32'(frame_len),   3);
        rd_check(0);
        chk("A done pulse width", 32'(frame_done), 0);
        rd_check(1);
        rd_check(2);
        release_frame();
        chk("A rel core_read_f", 32'(core_read_f), 1);
        chk("A rel ready",       32'(frame_ready), 0);

        // Frame B: same data, 2-cycle gap after first payload word
        drive(16'h0003);
        payload(0, 16'h000F);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("B gap done",        32'(frame_done),  0);
            chk("B gap core_read_f", 32'(core_read_f), 0);
        end
        payload(1, 16'h000F);
        chk("B w1 done", 32'(frame_done), 0);
        payload(2, 16'hABCD);
        chk("B done",      32'(frame_done), 1);
        chk("B frame_len", 32'(frame_len),  3);
        rd_check(0);
        rd_check(1);
        rd_check(2);
        release_frame();

        // Zero-length frame
        drive(16'h0000);
        chk("Z ready",     32'(frame_ready), 1);
        chk("Z done",      32'(frame_done),  1);
        chk("Z frame_len", 32'(frame_len),   0);
        step();
        chk("Z done pulse width", 32'(frame_done), 0);
        chk("Z core_read_f held", 32'(core_read_f), 0);
        release_frame();
        chk("Z rel core_read_f", 32'(core_read_f), 1);

        // Oversize header 0x41 followed by 65 discarded words
        drive(16'h0041);
        chk("D len_err",     32'(len_err),     1);
        chk("D core_read_f", 32'(core_read_f), 0);
        for (int i = 0; i < 64; i++) begin
            drive(16'h1000 + 16'(i));
        end
        chk("D 64th core_read_f", 32'(core_read_f), 0);
        drive(16'h1040);
        chk("D 65th core_read_f", 32'(core_read_f), 1);
        chk("D ready",            32'(frame_ready), 0);
        chk("D done",             32'(frame_done),  0);
        rd_check(0);
        rd_check(1);
        rd_check(2);

        // Two-word frame after the drop
        drive(16'h0002);
        payload(0, 16'h5555);
        payload(1, 16'hAAAA);
        chk("T done",      32'(frame_done), 1);
        chk("T frame_len", 32'(frame_len),  2);
        rd_check(0);
        rd_check(1);
        rd_check(2);

        // Word sent while READY
        drive(16'hBEEF);
        chk("P proto_err", 32'(proto_err),   1);
        chk("P ready",     32'(frame_ready), 1);
        chk("P done",      32'(frame_done),  0);
        rd_check(0);
        rd_check(1);
        release_frame();
        chk("P rel core_read_f", 32'(core_read_f), 1);
        drive(16'h0001);
        chk("P hdr core_read_f", 32'(core_read_f), 0);
        payload(0, 16'h1234);
        chk("P done",      32'(frame_done), 1);
        chk("P frame_len", 32'(frame_len),  1);
        rd_check(0);

        // Release and a word in the same READY cycle: release wins
        frame_release    = 1'b1;
        frame_being_sent = 1'b1;
        frame_word       = 16'h7777;
        step();
        frame_release    = 1'b0;
        frame_being_sent = 1'b0;
        frame_word       = '0;
        chk("R core_read_f", 32'(core_read_f), 1);
        chk("R ready",       32'(frame_ready), 0);
        chk("R proto_err",   32'(proto_err),   1);
        chk("R len_err",     32'(len_err),     1);
        rd_check(0);

        // Reset asserted after 2 of 3 payload words
        drive(16'h0003);
        payload(0, 16'h9999);
        payload(1, 16'h8888);
        #2;
        reset = 1'b0;
        #1;
        chk("X core_read_f", 32'(core_read_f), 1);
        chk("X ready",       32'(frame_ready), 0);
        chk("X frame_len",   32'(frame_len),   0);
        chk("X rd_data",     32'(rd_data),     0);
        chk("X done",        32'(frame_done),  0);
        chk("X len_err",     32'(len_err),     0);
        chk("X proto_err",   32'(proto_err),   0);
        frame_being_sent = 1'b1;
        frame_word       = 16'h7777;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("X held done", 32'(frame_done), 0);
        end
        frame_being_sent = 1'b0;
        frame_word       = '0;
        reset = 1'b1;
        step();
        chk("X post core_read_f", 32'(core_read_f), 1);
        chk("X post done",        32'(frame_done),  0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
